pi_pulse_arb: RTL and testbench

- Shares the single slow GPIO strobe/code pin group to the Raspberry Pi Zero between NREQ internal event requesters (RESET notify, hash-done, error, ...).
- Each 1-cycle request is latched. A round-robin arbiter grants one pending event at a time.
- The granted event is presented as a stable code plus a strobe that is long enough to survive jumper wiring. A quiet gap follows each event.

---
 rtl/pi_if_pkg.sv | 32 +++
 rtl/pi_pulse_arb_if.sv | 32 +++
 rtl/rr_arb.sv | 36 +++
 rtl/pi_pulse_arb.sv | 195 +++++++++++++++++++
 tb/tb_pi_pulse_arb.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pi_if_pkg.sv
// Shared types and default timing for the Pi pulse arbiter.
// Combinational helpers only; no latency or flow control.
// Constants only; nothing here sees backpressure.
package pi_if_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam int DEF_NREQ      = 4;
    localparam int DEF_CODE_W    = 3;
    localparam int DEF_SETUP_CYC = 256;
    localparam int DEF_HOLD_CYC  = 8191;
    localparam int DEF_GAP_CYC   = 4096;
    localparam int DEF_CNT_W     = 13;

    // Shortest strobe accepted before a Pi ack may end HOLD.
    localparam int ACK_MIN_CYC   = 16;

    // Code 0 on the pins means "no event".
    localparam int CODE_IDLE     = 0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pi_pulse_arb_if.sv
// Pin-group bundle between event requesters, the arbiter and the Pi.
// Wires only; no latency. Requests are fire-and-forget pulses, no backpressure.
// PI_ACK_EN adds the pi_ack input and ack_to timeout pulse.
interface pi_pulse_arb_if #(
    parameter int NREQ   = 4,
    parameter int CODE_W = 3
);
    logic [NREQ-1:0]   req;
    logic              pi_strobe;
    logic [CODE_W-1:0] pi_code;
    logic [NREQ-1:0]   pending;
    logic [NREQ-1:0]   ovf;
    logic              busy;
`ifdef PI_ACK_EN
    logic              pi_ack;
    logic              ack_to;

    modport master (output req, output pi_ack,
                    input  pi_strobe, input pi_code, input pending,
                    input  ovf, input busy, input ack_to);
    modport slave  (input  req, input pi_ack,
                    output pi_strobe, output pi_code, output pending,
                    output ovf, output busy, output ack_to);
`else
    modport master (output req,
                    input  pi_strobe, input pi_code, input pending,
                    input  ovf, input busy);
    modport slave  (input  req,
                    output pi_strobe, output pi_code, output pending,
                    output ovf, output busy);
`endif
endinterface

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first pending bit at or after ptr, wrapping.
// Zero latency; gnt is one-hot (or zero when nothing pends).
// No backpressure; the caller decides whether the grant is taken.
module rr_arb #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  pend,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] idx
);
    localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NREQ);

    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        pos   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(k);
            if (pos >= NREQ_W) begin
                pos = pos - NREQ_W;
            end
            if (!found && pend[pos[IDX_W-1:0]]) begin
                found                 = 1'b1;
                gnt[pos[IDX_W-1:0]]   = 1'b1;
                idx                   = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/pi_pulse_arb.sv
// Latches 1-cycle event requests and round-robins them onto a slow strobe/code pin group.
// Grant 1 cycle after a request is latched; then SETUP, HOLD, GAP phases of fixed length.
// No backpressure: repeat requests merge into pending and flag ovf. Macro PI_ACK_EN adds Pi ack.
module pi_pulse_arb
    import pi_if_pkg::*;
#(
    parameter int NREQ      = DEF_NREQ,
    parameter int CODE_W    = DEF_CODE_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    pi_pulse_arb_if.slave  bus
);
    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    if (NREQ < 2 || NREQ > 8 || CODE_W == 0 || CNT_W == 0 || CNT_W > 30 ||
        SETUP_CYC == 0 || HOLD_CYC == 0 || GAP_CYC == 0) begin : g_bad_param
        $error("pi_pulse_arb: illegal parameter value");
    end
    if (NREQ + 1 > (1 << CODE_W)) begin : g_bad_code_w
        $error("pi_pulse_arb: CODE_W too narrow for NREQ codes plus idle");
    end
    if (max3(SETUP_CYC, HOLD_CYC, GAP_CYC) > (1 << CNT_W) - 1) begin : g_bad_cnt_w
        $error("pi_pulse_arb: CNT_W too narrow for timing parameters");
    end

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [CODE_W-1:0] code_q, code_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [NREQ-1:0]   pending_q, pending_d;
    logic [NREQ-1:0]   ovf_q, ovf_d;
    logic [CODE_W-1:0] pi_code_q, pi_code_d;
    logic              pi_strobe_q, pi_strobe_d;
    logic [NREQ-1:0]   grant, clr;
    logic [IDX_W-1:0]  gnt_idx;
    logic              take;

`ifdef PI_ACK_EN
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_MIN_CYC - 1);
    logic ack_s1_q, ack_s1_d, ack_s2_q, ack_s2_d;
    logic ack_to_q, ack_to_d;
`endif

    rr_arb #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_arb (
        .pend (pending_q),
        .ptr  (ptr_q),
        .gnt  (grant),
        .idx  (gnt_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            ptr_q       <= '0;
            pending_q   <= '0;
            ovf_q       <= '0;
            pi_code_q   <= '0;
            pi_strobe_q <= 1'b0;
`ifdef PI_ACK_EN
            ack_s1_q    <= 1'b0;
            ack_s2_q    <= 1'b0;
            ack_to_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            ptr_q       <= ptr_d;
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            pi_code_q   <= pi_code_d;
            pi_strobe_q <= pi_strobe_d;
`ifdef PI_ACK_EN
            ack_s1_q    <= ack_s1_d;
            ack_s2_q    <= ack_s2_d;
            ack_to_q    <= ack_to_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        ptr_d   = ptr_q;
        take    = 1'b0;
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
`ifdef PI_ACK_EN
        ack_s1_d = bus.pi_ack;
        ack_s2_d = ack_s1_q;
        ack_to_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    take    = 1'b1;
                    state_d = SETUP;
                    cnt_d   = '0;
                    code_d  = CODE_W'(gnt_idx) + CODE_W'(1);
                    ptr_d   = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + IDX_W'(1);
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HOLD: begin
`ifdef PI_ACK_EN
                if (ack_s2_q && cnt_q >= ACK_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (cnt_q == HOLD_LAST) begin
                    cnt_d    = '0;
                    state_d  = GAP;
                    ack_to_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
`else
                if (cnt_q == HOLD_LAST) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
`endif
            end
            GAP: begin
`ifdef PI_ACK_EN
                // The Pi must also release its ack before the next event.
                if (cnt_q >= GAP_LAST && !ack_s2_q) begin
`else
                if (cnt_q == GAP_LAST) begin
`endif
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A request landing in its own grant cycle re-arms pending (set wins).
    always_comb begin
        clr       = take ? grant : '0;
        pending_d = (pending_q & ~clr) | bus.req;
        ovf_d     = bus.req & pending_q & ~clr;
    end

    always_comb begin
        pi_code_d   = CODE_W'(CODE_IDLE);
        pi_strobe_d = 1'b0;
        case (state_d)
            SETUP: pi_code_d = code_d;
            HOLD: begin
                pi_code_d   = code_d;
                pi_strobe_d = 1'b1;
            end
            default: begin
                pi_code_d   = CODE_W'(CODE_IDLE);
                pi_strobe_d = 1'b0;
            end
        endcase
    end

    assign bus.pi_strobe = pi_strobe_q;
    assign bus.pi_code   = pi_code_q;
    assign bus.pending   = pending_q;
    assign bus.ovf       = ovf_q;
    assign bus.busy      = (state_q != IDLE);
`ifdef PI_ACK_EN
    assign bus.ack_to    = ack_to_q;
`endif

endmodule

// File: tb/tb_pi_pulse_arb.sv
// Scoreboarded bench for pi_pulse_arb with shortened timing parameters.
module tb_pi_pulse_arb;

    localparam int NREQ      = 4;
    localparam int CODE_W    = 3;
    localparam int SETUP_CYC = 8;
    localparam int HOLD_CYC  = 20;
    localparam int GAP_CYC   = 12;
    localparam int CNT_W     = 5;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pi_pulse_arb_if #(.NREQ(NREQ), .CODE_W(CODE_W)) bus ();

    pi_pulse_arb #(
        .NREQ(NREQ), .CODE_W(CODE_W), .SETUP_CYC(SETUP_CYC),
        .HOLD_CYC(HOLD_CYC), .GAP_CYC(GAP_CYC), .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int exp_q[$];
    int ph = 0;
    int cnt = 0;
    int cur_code = 0;
    int n_evt = 0;
    int ovf_cnt[NREQ];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    // Event monitor: pops the scoreboard at each event start and times every phase.
    always @(negedge clk) begin
        if (!rst_n) begin
            ph  = 0;
            cnt = 0;
        end else begin
            for (int i = 0; i < NREQ; i++) if (bus.ovf[i]) ovf_cnt[i]++;
            case (ph)
                0: begin
                    if (bus.pi_code != 0) begin
                        n_evt++;
                        if (exp_q.size() == 0) check_eq("unexpected_event", int'(bus.pi_code), 0);
                        else check_eq("event_code", int'(bus.pi_code), exp_q.pop_front());
                        check_eq("strobe_low_at_setup", int'(bus.pi_strobe), 0);
                        cur_code = int'(bus.pi_code);
                        ph  = 1;
                        cnt = 1;
                    end else if (bus.pi_strobe) begin
                        check_eq("strobe_while_idle", int'(bus.pi_strobe), 0);
                    end
                end
                1: begin
                    if (int'(bus.pi_code) != cur_code) check_eq("setup_code_stable", int'(bus.pi_code), cur_code);
                    if (bus.pi_strobe) begin
                        check_eq("setup_len", cnt, SETUP_CYC);
                        ph  = 2;
                        cnt = 1;
                    end else cnt++;
                end
                2: begin
                    if (!bus.pi_strobe) begin
                        check_eq("hold_len", cnt, HOLD_CYC);
                        check_eq("gap_code", int'(bus.pi_code), 0);
                        ph  = 3;
                        cnt = 1;
                    end else begin
                        cnt++;
                        if (int'(bus.pi_code) != cur_code) check_eq("hold_code_stable", int'(bus.pi_code), cur_code);
                    end
                end
                default: begin
                    if (!bus.busy) begin
                        check_eq("gap_len", cnt, GAP_CYC);
                        ph = 0;
                    end else begin
                        cnt++;
                        if (bus.pi_code != 0 || bus.pi_strobe)
                            check_eq("gap_quiet", int'({bus.pi_strobe, bus.pi_code}), 0);
                    end
                end
            endcase
        end
    end

    task automatic pulse_req(input logic [NREQ-1:0] v, input int ncyc);
        @(posedge clk); #1;
        bus.req = v;
        repeat (ncyc) @(posedge clk);
        #1;
        bus.req = '0;
    endtask

    task automatic wait_idle(input int maxc);
        int k = 0;
        while (!(bus.busy == 1'b0 && bus.pending == '0) && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= maxc) check_eq("wait_idle_timeout", int'({bus.busy, bus.pending}), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_code(input int c, input int maxc);
        int k = 0;
        while (int'(bus.pi_code) != c && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= maxc) check_eq("wait_code_timeout", int'(bus.pi_code), c);
    endtask

    task automatic wait_strobe(input int maxc);
        int k = 0;
        while (!bus.pi_strobe && k < maxc) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= maxc) check_eq("wait_strobe_timeout", int'(bus.pi_strobe), 1);
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int e0;
        int o_snap;
        for (int i = 0; i < NREQ; i++) ovf_cnt[i] = 0;
        rst_n   = 1'b0;
        bus.req = '0;
`ifdef PI_ACK_EN
        bus.pi_ack = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_strobe",  int'(bus.pi_strobe), 0);
        check_eq("rst_code",    int'(bus.pi_code), 0);
        check_eq("rst_pending", int'(bus.pending), 0);
        check_eq("rst_ovf",     int'(bus.ovf), 0);
        check_eq("rst_busy",    int'(bus.busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single event from requester 1.
        e0 = n_evt;
        exp_q.push_back(2);
        pulse_req(4'b0010, 1);
        check_eq("t1_pending_latched", int'(bus.pending), 2);
        check_eq("t1_busy_before_grant", int'(bus.busy), 0);
        @(posedge clk); #1;
        check_eq("t1_busy_after_grant", int'(bus.busy), 1);
        check_eq("t1_pending_cleared", int'(bus.pending), 0);
        check_eq("t1_code_at_setup", int'(bus.pi_code), 2);
        wait_idle(200);
        check_eq("t1_events", n_evt - e0, 1);

        // Simultaneous requests from pointer 0, then a wrap back to requester 0.
        do_reset();
        e0 = n_evt;
        exp_q.push_back(1);
        exp_q.push_back(2);
        exp_q.push_back(4);
        pulse_req(4'b1011, 1);
        check_eq("t2_pending", int'(bus.pending), 11);
        wait_code(4, 400);
        exp_q.push_back(1);
        pulse_req(4'b0001, 1);
        wait_idle(400);
        check_eq("t2_events", n_evt - e0, 4);
        check_eq("t2_queue_empty", exp_q.size(), 0);

        // Two requests from requester 2 during another HOLD merge into one event.
        e0 = n_evt;
        o_snap = ovf_cnt[2];
        exp_q.push_back(1);
        pulse_req(4'b0001, 1);
        wait_strobe(100);
        exp_q.push_back(3);
        pulse_req(4'b0100, 1);
        check_eq("t3_no_ovf_first", int'(bus.ovf), 0);
        repeat (2) @(posedge clk);
        pulse_req(4'b0100, 1);
        check_eq("t3_ovf_pulse", int'(bus.ovf), 4);
        @(posedge clk); #1;
        check_eq("t3_ovf_one_cycle", int'(bus.ovf), 0);
        wait_idle(400);
        check_eq("t3_ovf_count", ovf_cnt[2] - o_snap, 1);
        check_eq("t3_events", n_evt - e0, 2);

        // Request in its own grant cycle stays pending (set wins).
        e0 = n_evt;
        o_snap = ovf_cnt[0];
        exp_q.push_back(1);
        exp_q.push_back(1);
        pulse_req(4'b0001, 2);
        check_eq("t4_pending_kept", int'(bus.pending), 1);
        check_eq("t4_busy", int'(bus.busy), 1);
        check_eq("t4_code", int'(bus.pi_code), 1);
        wait_idle(400);
        check_eq("t4_events", n_evt - e0, 2);
        check_eq("t4_no_ovf", ovf_cnt[0] - o_snap, 0);

        // Asynchronous reset in the middle of HOLD.
        exp_q.push_back(2);
        pulse_req(4'b0010, 1);
        wait_strobe(100);
        pulse_req(4'b0001, 1);
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t5_strobe_async", int'(bus.pi_strobe), 0);
        check_eq("t5_code_async", int'(bus.pi_code), 0);
        check_eq("t5_pending_async", int'(bus.pending), 0);
        check_eq("t5_busy_async", int'(bus.busy), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e0 = n_evt;
        repeat (30) @(posedge clk);
        #1;
        check_eq("t5_idle_busy", int'(bus.busy), 0);
        check_eq("t5_idle_code", int'(bus.pi_code), 0);
        check_eq("t5_no_new_event", n_evt - e0, 0);

        check_eq("final_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
